nibble_serial_adder_ctrl: RTL and testbench

- Multi-precision adder/subtractor controller built around one 4-bit ripple-carry slice.
- Accepts WIDTH-bit operands through a valid/ready handshake.
- Sequences the slice over WIDTH/4 cycles, least-significant nibble first, with a registered inter-nibble carry.
- Returns sum, carry-out and signed overflow through a second valid/ready handshake; serves as the arithmetic unit for wider datapaths that reuse the 4-bit adder.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 19 +
 rtl/nibble_serial_adder_ctrl_if.sv | 29 ++
 rtl/nibble_serial_adder_ctrl_rca4_slice.sv | 22 ++
 rtl/nibble_serial_adder_ctrl.sv | 130 +++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor controller.
package nibble_serial_adder_ctrl_pkg;

   // Width of the single ripple-carry slice that is reused every cycle.
   localparam int NIBBLE_W = 4;

   // Controller sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Bits needed to index n nibbles; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle between a requester and the controller.
interface nibble_serial_adder_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   // Requester side: presents operands, consumes results.
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, busy
   );

   // Controller side.
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, busy
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl_rca4_slice.sv
// Combinational 4-bit ripple-carry adder made of full-adder cells.
module rca4_slice
   import nibble_serial_adder_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);
   logic [NIBBLE_W:0] carry;

   assign carry[0] = cin;

   // One full-adder cell per bit, carry rippling upward.
   for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
   end

   assign cout = carry[NIBBLE_W];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-precision add/subtract controller: walks one 4-bit slice across the
// operands LS nibble first, carrying between nibbles through a register.
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   nibble_serial_adder_ctrl_if.slave   bus
);
   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int IDX_W = cnt_width(NIB);
   localparam int MSB   = WIDTH - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [NIBBLE_W-1:0] opa_nib [NIB];
   logic [NIBBLE_W-1:0] opb_nib [NIB];
   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;

   // Split the operand registers into nibbles so the slice input is a plain mux.
   for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign opa_nib[gi] = opa_q[gi*NIBBLE_W +: NIBBLE_W];
      assign opb_nib[gi] = opb_q[gi*NIBBLE_W +: NIBBLE_W];
   end

   rca4_slice u_slice (
      .a    (opa_nib[idx_q]),
      .b    (opb_nib[idx_q]),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Next-state and datapath logic; handshake flags follow the next state so
   // they come straight from flops.
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               // Subtract is A + ~B + 1, so cin is replaced by the forced 1.
               opa_d   = bus.a;
               opb_d   = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? 1'b1 : bus.cin;
               idx_d   = '0;
               sum_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < NIB; i++) begin
               if (idx_q == IDX_W'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
            end
            carry_d = slice_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               // Top nibble: slice MSB is the result MSB.
               cout_d  = slice_cout;
               ovf_d   = (opa_q[MSB] == opb_q[MSB]) &&
                         (slice_sum[NIBBLE_W-1] != opa_q[MSB]);
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   // State and result registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         opa_q       <= '0;
         opb_q       <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed and randomized checks of the nibble-serial adder controller.
module tb_nibble_serial_adder_ctrl;
   localparam int W = 16;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, result packed as {ovf, cout, sum}.
   function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic su);
      int          ua, ub, sa, sb, full, sres;
      logic        co, ov;
      logic [15:0] s;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (!su) begin
         full = ua + ub + int'(ci);
         s    = full[15:0];
         co   = (full > 32'h0000_FFFF);
         sres = sa + sb + int'(ci);
      end else begin
         full = ua - ub;
         s    = full[15:0];
         co   = (ua >= ub);
         sres = sa - sb;
      end
      ov = (sres > 32767) || (sres < -32768);
      return {ov, co, s};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One full transaction; 'hold' cycles of result backpressure with in_valid pulses.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic su, input int hold);
      logic [17:0] e;
      int          n;
      e = model(a, b, ci, su);
      bus.a        = a;
      bus.b        = b;
      bus.cin      = ci;
      bus.sub      = su;
      bus.in_valid = 1'b1;
      chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      chk("busy_run", 32'(bus.busy), 32'd1);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         tick();
         n++;
      end
      chk("latency", 32'(n), 32'd4);
      chk("sum", 32'(bus.sum), 32'(e[15:0]));
      chk("cout", 32'(bus.cout), 32'(e[16]));
      chk("ovf", 32'(bus.ovf), 32'(e[17]));
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = 16'($urandom);
         tick();
         chk("bp_sum", 32'({bus.ovf, bus.cout, bus.sum}), 32'(e));
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
      chk("in_ready_back", 32'(bus.in_ready), 32'd1);
      chk("idle_retain", 32'({bus.ovf, bus.cout, bus.sum}), 32'(e));
      $display("op a=%04h b=%04h cin=%0d sub=%0d -> sum=%04h cout=%0d ovf=%0d",
               a, b, ci, su, bus.sum, bus.cout, bus.ovf);
   endtask

   logic [17:0] exp_q[$];
   logic [17:0] e_front;
   int          acc_cnt, res_cnt, last_acc, cyc;
   logic [15:0] ra, rb;
   logic        rc, rs;

   initial begin
      n_total       = 0;
      n_pass        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      repeat (2) tick();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'd0);
      #2 rst_n = 1'b1;

      // Directed arithmetic cases.
      do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
      do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
      do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);

      // Backpressure on the result.
      do_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 6);

      // Reset during nibble 2.
      bus.a        = 16'h1234;
      bus.b        = 16'h4321;
      bus.cin      = 1'b0;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'd0);
      tick();
      #2 rst_n = 1'b1;
      do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);

      // Back-to-back random operations with both handshakes held open.
      acc_cnt  = 0;
      res_cnt  = 0;
      last_acc = -1;
      cyc      = 0;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      bus.a = ra; bus.b = rb; bus.cin = rc; bus.sub = rs;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      while (res_cnt < 4 && cyc < 100) begin
         if (bus.out_valid) begin
            e_front = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
            chk("rand_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'(e_front));
            $display("rand result %0d: sum=%04h cout=%0d ovf=%0d", res_cnt,
                     bus.sum, bus.cout, bus.ovf);
            res_cnt++;
         end
         if (bus.in_ready && bus.in_valid) begin
            exp_q.push_back(model(ra, rb, rc, rs));
            if (last_acc >= 0) chk("accept_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            acc_cnt++;
         end
         tick();
         cyc++;
         if (!bus.busy) begin
            // No acceptance happened on this edge; keep operands.
         end else if (acc_cnt > 0 && last_acc == cyc - 1) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            bus.a = ra; bus.b = rb; bus.cin = rc; bus.sub = rs;
            if (acc_cnt == 4) bus.in_valid = 1'b0;
         end
      end
      chk("rand_results_seen", 32'(res_cnt), 32'd4);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
